mopshub_power_trim_seq: RTL and testbench

//  Per-bus power-up and oscillator-trim sequencer in the MOPSHUB init path, between the init controller and
//  the trimming block. On start_init it steps power_bus_cnt through buses 0..n_buses, strobing power_bus_en
//  and waiting a settle time for each bus. It optionally requests an oscillator trim and waits for the

---
 rtl/mopshub_power_trim_seq.sv | 157 +++++++++++++++
 tb/tb_mopshub_power_trim_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mopshub_power_trim_seq.sv
// Per-bus power-up and oscillator-trim sequencer: powers buses 0..n_buses in order,
// waits a settle time per bus and optionally runs a trim handshake with timeout and retry.
module mopshub_power_trim_seq #(
    parameter logic [15:0] SETTLE_CYC   = 16'd400,
    parameter logic [19:0] TRIM_TIMEOUT = 20'd100000,
    parameter logic [1:0]  RETRY_MAX    = 2'd2
) (
    input  logic        clk_40_m,
    input  logic        rst,
    input  logic        start_init,
    input  logic [4:0]  n_buses,
    input  logic        osc_auto_trim,
    input  logic        end_trim_bus,
    output logic        power_bus_en,
    output logic [4:0]  power_bus_cnt,
    output logic        start_trim_ack,
    output logic [31:0] power_mask,
    output logic [31:0] trim_fail,
    output logic        end_power_init,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POWER_ON  = 3'd1,
        SETTLE    = 3'd2,
        TRIM_REQ  = 3'd3,
        TRIM_WAIT = 3'd4,
        NEXT      = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] settle_cnt;
    logic [15:0] settle_nxt;
    logic [19:0] tmo_cnt;
    logic [19:0] tmo_nxt;
    logic [1:0]  retries;
    logic [1:0]  retries_nxt;
    logic [4:0]  n_lat;
    logic [4:0]  n_lat_nxt;
    logic        trim_lat;
    logic        trim_lat_nxt;
    logic [4:0]  cnt_nxt;
    logic [31:0] mask_nxt;
    logic [31:0] fail_nxt;

    always_comb begin
        state_nxt    = state;
        settle_nxt   = settle_cnt;
        tmo_nxt      = tmo_cnt;
        retries_nxt  = retries;
        n_lat_nxt    = n_lat;
        trim_lat_nxt = trim_lat;
        cnt_nxt      = power_bus_cnt;
        mask_nxt     = power_mask;
        fail_nxt     = trim_fail;

        case (state)
            IDLE: begin
                if (start_init) begin
                    n_lat_nxt    = n_buses;
                    trim_lat_nxt = osc_auto_trim;
                    mask_nxt     = '0;
                    fail_nxt     = '0;
                    cnt_nxt      = '0;
                    retries_nxt  = '0;
                    state_nxt    = POWER_ON;
                end
            end
            POWER_ON: begin
                mask_nxt[power_bus_cnt] = 1'b1;
                settle_nxt              = SETTLE_CYC;
                state_nxt               = SETTLE;
            end
            SETTLE: begin
                // Counter was loaded with SETTLE_CYC; leaving at 1 gives exactly that many cycles here.
                if (settle_cnt <= 16'd1) begin
                    state_nxt = trim_lat ? TRIM_REQ : NEXT;
                end else begin
                    settle_nxt = settle_cnt - 16'd1;
                end
            end
            TRIM_REQ: begin
                tmo_nxt   = TRIM_TIMEOUT;
                state_nxt = TRIM_WAIT;
            end
            TRIM_WAIT: begin
                // A done pulse on the expiry cycle wins over the timeout.
                if (end_trim_bus) begin
                    retries_nxt = '0;
                    state_nxt   = NEXT;
                end else if (tmo_cnt <= 20'd1) begin
                    if (retries < RETRY_MAX) begin
                        retries_nxt = retries + 2'd1;
                        state_nxt   = TRIM_REQ;
                    end else begin
                        fail_nxt[power_bus_cnt] = 1'b1;
                        retries_nxt             = '0;
                        state_nxt               = NEXT;
                    end
                end else begin
                    tmo_nxt = tmo_cnt - 20'd1;
                end
            end
            NEXT: begin
                if ((power_bus_cnt == n_lat) || (power_bus_cnt == 5'd31)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = power_bus_cnt + 5'd1;
                    state_nxt = POWER_ON;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so each one is high exactly while the FSM sits in its state.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            tmo_cnt        <= '0;
            retries        <= '0;
            n_lat          <= '0;
            trim_lat       <= 1'b0;
            power_bus_cnt  <= '0;
            power_mask     <= '0;
            trim_fail      <= '0;
            power_bus_en   <= 1'b0;
            start_trim_ack <= 1'b0;
            end_power_init <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            settle_cnt     <= settle_nxt;
            tmo_cnt        <= tmo_nxt;
            retries        <= retries_nxt;
            n_lat          <= n_lat_nxt;
            trim_lat       <= trim_lat_nxt;
            power_bus_cnt  <= cnt_nxt;
            power_mask     <= mask_nxt;
            trim_fail      <= fail_nxt;
            power_bus_en   <= (state_nxt == POWER_ON);
            start_trim_ack <= (state_nxt == TRIM_REQ);
            end_power_init <= (state_nxt == DONE);
            busy           <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mopshub_power_trim_seq.sv
// Bench for mopshub_power_trim_seq: directed and randomized sequences compared against an
// event-timeline model derived from the per-state cycle counts.
module tb_mopshub_power_trim_seq;

    localparam int S    = 4;
    localparam int T    = 10;
    localparam int RMAX = 1;

    logic        clk_40_m;
    logic        rst;
    logic        start_init;
    logic [4:0]  n_buses;
    logic        osc_auto_trim;
    logic        end_trim_bus;
    logic        power_bus_en;
    logic [4:0]  power_bus_cnt;
    logic        start_trim_ack;
    logic [31:0] power_mask;
    logic [31:0] trim_fail;
    logic        end_power_init;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int resp_delay [64];
    int en_rel_q [$];
    int en_cnt_q [$];
    int ack_q [$];
    int end_q [$];
    logic [31:0] obs_mask;
    logic [31:0] obs_fail;
    int exp_en_rel [$];
    int exp_en_cnt [$];
    int exp_ack [$];
    int exp_end;
    logic [31:0] exp_mask;
    logic [31:0] exp_fail;

    mopshub_power_trim_seq #(
        .SETTLE_CYC   (16'(S)),
        .TRIM_TIMEOUT (20'(T)),
        .RETRY_MAX    (2'(RMAX))
    ) dut (
        .clk_40_m       (clk_40_m),
        .rst            (rst),
        .start_init     (start_init),
        .n_buses        (n_buses),
        .osc_auto_trim  (osc_auto_trim),
        .end_trim_bus   (end_trim_bus),
        .power_bus_en   (power_bus_en),
        .power_bus_cnt  (power_bus_cnt),
        .start_trim_ack (start_trim_ack),
        .power_mask     (power_mask),
        .trim_fail      (trim_fail),
        .end_power_init (end_power_init),
        .busy           (busy)
    );

    initial clk_40_m = 1'b0;
    always #5 clk_40_m = ~clk_40_m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timeline model: POWER_ON, S settle cycles, then either NEXT or trim attempts of
    // (1 request + response delay) or (1 request + T wait cycles), then NEXT; DONE follows the last NEXT.
    task automatic model(input int n, input bit trim);
        int t;
        int a;
        int r;
        int d;
        int rt;
        bit fin;
        logic [63:0] m;
        exp_en_rel.delete();
        exp_en_cnt.delete();
        exp_ack.delete();
        exp_fail = '0;
        t = 1;
        a = 0;
        for (int b = 0; b <= n; b++) begin
            exp_en_rel.push_back(t);
            exp_en_cnt.push_back(b);
            t = t + 1 + S;
            if (trim) begin
                rt  = 0;
                fin = 1'b0;
                while (!fin) begin
                    r = t;
                    exp_ack.push_back(r);
                    d = resp_delay[a];
                    a++;
                    if (d >= 1 && d <= T) begin
                        t   = r + d + 1;
                        fin = 1'b1;
                    end else begin
                        t = r + T + 1;
                        if (rt < RMAX) rt++;
                        else begin
                            exp_fail[b] = 1'b1;
                            fin         = 1'b1;
                        end
                    end
                end
            end
            t = t + 1;
        end
        exp_end  = t;
        m        = (64'd1 << (n + 1)) - 64'd1;
        exp_mask = m[31:0];
    endtask

    task automatic run_seq(input int n, input bit trim, input int rst_rel, input int spur_rel,
                           input int dup_rel, input int budget);
        int rel;
        int trim_due;
        int ack_idx;
        int end_rel;
        bit fin;
        en_rel_q.delete();
        en_cnt_q.delete();
        ack_q.delete();
        end_q.delete();
        obs_mask = 'x;
        obs_fail = 'x;
        @(negedge clk_40_m);
        n_buses       = 5'(n);
        osc_auto_trim = trim;
        start_init    = 1'b1;
        @(negedge clk_40_m);
        start_init    = 1'b0;
        n_buses       = 5'($urandom);
        osc_auto_trim = 1'($urandom);
        rel      = 1;
        trim_due = -1;
        ack_idx  = 0;
        end_rel  = -1;
        fin      = 1'b0;
        while (!fin) begin
            if (rel == 1) chk("busy_at_start", 64'(busy), 64'd1);
            if (power_bus_en) begin
                en_rel_q.push_back(rel);
                en_cnt_q.push_back(int'(power_bus_cnt));
            end
            if (start_trim_ack) begin
                ack_q.push_back(rel);
                trim_due = (resp_delay[ack_idx] > 0) ? rel + resp_delay[ack_idx] : -1;
                ack_idx++;
            end
            if (end_power_init) begin
                end_q.push_back(rel);
                obs_mask = power_mask;
                obs_fail = trim_fail;
                if (end_rel < 0) end_rel = rel;
            end
            if (rst_rel > 0 && rel == rst_rel) begin
                chk("cnt_before_rst", 64'(power_bus_cnt), 64'd2);
                rst = 1'b0;
            end
            if (rst_rel > 0 && rel == rst_rel + 1) begin
                chk("rst_mid_en", 64'(power_bus_en), 64'd0);
                chk("rst_mid_cnt", 64'(power_bus_cnt), 64'd0);
                chk("rst_mid_ack", 64'(start_trim_ack), 64'd0);
                chk("rst_mid_mask", 64'(power_mask), 64'd0);
                chk("rst_mid_fail", 64'(trim_fail), 64'd0);
                chk("rst_mid_end", 64'(end_power_init), 64'd0);
                chk("rst_mid_busy", 64'(busy), 64'd0);
                rst = 1'b1;
                fin = 1'b1;
            end
            if (end_rel > 0 && rel == end_rel + 1) begin
                chk("busy_after_end", 64'(busy), 64'd0);
                fin = 1'b1;
            end
            if (!fin && rel >= budget) begin
                checks++;
                failures++;
                $error("FAIL run_timeout observed=rel%0d expected=end_power_init", rel);
                fin = 1'b1;
            end
            end_trim_bus = (rel == trim_due) || (rel == spur_rel);
            start_init   = (rel == dup_rel);
            if (!fin) begin
                @(negedge clk_40_m);
                rel++;
            end
        end
        end_trim_bus = 1'b0;
        start_init   = 1'b0;
        rst          = 1'b1;
    endtask

    task automatic compare_run(input string tag);
        chk({tag, "_en_count"}, 64'(en_rel_q.size()), 64'(exp_en_rel.size()));
        for (int i = 0; i < en_rel_q.size() && i < exp_en_rel.size(); i++) begin
            chk($sformatf("%s_en_rel%0d", tag, i), 64'(en_rel_q[i]), 64'(exp_en_rel[i]));
            chk($sformatf("%s_en_cnt%0d", tag, i), 64'(en_cnt_q[i]), 64'(exp_en_cnt[i]));
        end
        chk({tag, "_ack_count"}, 64'(ack_q.size()), 64'(exp_ack.size()));
        for (int i = 0; i < ack_q.size() && i < exp_ack.size(); i++)
            chk($sformatf("%s_ack_rel%0d", tag, i), 64'(ack_q[i]), 64'(exp_ack[i]));
        chk({tag, "_end_count"}, 64'(end_q.size()), 64'd1);
        if (end_q.size() > 0) chk({tag, "_end_rel"}, 64'(end_q[0]), 64'(exp_end));
        chk({tag, "_mask"}, 64'(obs_mask), 64'(exp_mask));
        chk({tag, "_fail"}, 64'(obs_fail), 64'(exp_fail));
    endtask

    initial begin
        int n;
        bit trim;
        int rr;
        rst           = 1'b0;
        start_init    = 1'b0;
        n_buses       = '0;
        osc_auto_trim = 1'b0;
        end_trim_bus  = 1'b0;
        foreach (resp_delay[i]) resp_delay[i] = 0;
        repeat (3) @(negedge clk_40_m);
        chk("reset_en", 64'(power_bus_en), 64'd0);
        chk("reset_cnt", 64'(power_bus_cnt), 64'd0);
        chk("reset_ack", 64'(start_trim_ack), 64'd0);
        chk("reset_mask", 64'(power_mask), 64'd0);
        chk("reset_fail", 64'(trim_fail), 64'd0);
        chk("reset_end", 64'(end_power_init), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk_40_m);

        // Plain power-up of four buses with known absolute timing.
        model(3, 1'b0);
        run_seq(3, 1'b0, -1, -1, -1, 200);
        compare_run("t1");
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_abs_en%0d", i), 64'((en_rel_q.size() > i) ? en_rel_q[i] : -1), 64'(1 + 6 * i));
        chk("t1_abs_end", 64'((end_q.size() > 0) ? end_q[0] : -1), 64'd25);
        chk("t1_abs_mask", 64'(obs_mask), 64'h0000000F);

        // Trim answered 3 cycles after each request.
        resp_delay[0] = 3;
        resp_delay[1] = 3;
        model(1, 1'b1);
        run_seq(1, 1'b1, -1, -1, -1, 200);
        compare_run("t2");

        // Trim never answered: one retry, then sticky failure.
        resp_delay[0] = 0;
        resp_delay[1] = 0;
        model(0, 1'b1);
        run_seq(0, 1'b1, -1, -1, -1, 200);
        compare_run("t3");
        chk("t3_ack_gap", 64'((ack_q.size() > 1) ? ack_q[1] - ack_q[0] : -1), 64'd11);
        chk("t3_abs_fail", 64'(obs_fail), 64'h1);

        // Done pulse on the expiry cycle counts as success; spurious pulse in settle is ignored.
        resp_delay[0] = T;
        resp_delay[1] = T;
        model(1, 1'b1);
        run_seq(1, 1'b1, -1, 3, -1, 200);
        compare_run("t4");
        chk("t4_abs_acks", 64'(ack_q.size()), 64'd2);

        // All 32 buses, no wrap; a second start while busy is ignored.
        model(31, 1'b0);
        run_seq(31, 1'b0, -1, -1, 50, 400);
        compare_run("t5");
        chk("t5_abs_mask", 64'(obs_mask), 64'hFFFFFFFF);
        chk("t5_last_cnt", 64'((en_cnt_q.size() > 0) ? en_cnt_q[en_cnt_q.size() - 1] : -1), 64'd31);

        // Reset three cycles into the first trim wait of bus 2, then restart.
        foreach (resp_delay[i]) resp_delay[i] = 0;
        model(4, 1'b1);
        rr = exp_ack[4] + 3;
        run_seq(4, 1'b1, rr, -1, -1, 400);
        chk("t6_en_before_rst", 64'(en_rel_q.size()), 64'd3);
        chk("t6_end_before_rst", 64'(end_q.size()), 64'd0);
        model(2, 1'b0);
        run_seq(2, 1'b0, -1, -1, -1, 200);
        compare_run("t6_restart");

        for (int k = 0; k < 6; k++) begin
            n    = $urandom_range(0, 5);
            trim = 1'($urandom_range(0, 1));
            foreach (resp_delay[i])
                resp_delay[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, T);
            model(n, trim);
            run_seq(n, trim, -1, -1, -1, 1000);
            compare_run($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
